// File: rtl/retire_stage_pkg.sv
// retire_stage_pkg -- shared types for the retire stage.
//   Defines the ROB entry layout, index/tag/address widths, the ROB size used
//   for index wrap-around, and the retire FSM state enum.
//   Also supplies the default retire width `N when the build does not set it.
`ifndef N
`define N 3
`endif

package retire_stage_pkg;

  localparam int ROB_SZ     = 32;
  localparam int ROB_IDX_W  = $clog2(ROB_SZ);
  localparam int PHYS_TAG_W = 6;
  localparam int REG_IDX_W  = 5;
  localparam int ADDR_W     = 32;

  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  typedef struct packed {
    logic      valid;
    logic      complete;
    logic      has_dest;
    reg_idx_t  dest_areg;
    phys_tag_t dest_preg;
    phys_tag_t old_preg;
    logic      is_branch;
    logic      mispredict;
    addr_t     target_pc;
    logic      halt;
  } rob_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HALTED  = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_stage_select.sv
// retire_select -- in-order retire eligibility.
//   Walks the head slots oldest-first and retires the longest prefix of
//   available slots. A stopping slot (halt or mispredicted branch) retires
//   itself and closes the group.
// Ports:
//   enable  : 1 when retirement is allowed this cycle
//   avail   : per-slot occupied-and-complete
//   stop    : per-slot halt / mispredicted branch
//   retire  : per-slot retire mask
//   count   : number of retired slots
`ifndef N
`define N 3
`endif

module retire_select #(
  parameter int N = `N
) (
  input  logic         enable,
  input  logic [N-1:0] avail,
  input  logic [N-1:0] stop,
  output logic [N-1:0] retire,
  output logic [N:0]   count
);

  logic run_on;

  always_comb begin
    retire = '0;
    count  = '0;
    run_on = enable;
    for (int i = 0; i < N; i++) begin
      if (run_on && avail[i]) begin
        retire[i] = 1'b1;
        count     = count + {{N{1'b0}}, 1'b1};
        if (stop[i]) run_on = 1'b0;
      end else begin
        // A missing or incomplete slot ends the group, so a valid gap
        // blocks everything younger.
        run_on = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_stage.sv
// retire_stage -- in-order commit of the oldest N ROB entries.
//   Retires the eligible prefix each cycle, releases old physical tags,
//   updates the architectural map, and handles mispredict recovery and halt.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   head_entries/_valids    : oldest N ROB entries (slot 0 = head) and occupancy
//   head_idx                : ROB index of slot 0
//   retire_count            : combinational count retired this cycle
//   mispredict/mispred_idx/recover_pc : one-cycle squash pulse and its target
//   free_valid/free_pregs   : old tags released (registered)
//   amt_valid/amt_areg/amt_preg : map table writes (registered)
//   halted                  : high once a halt has retired
//   instret                 : retired-instruction counter, present only when
//                             RETIRE_STATS_EN is defined
`ifndef N
`define N 3
`endif

module retire_stage
  import retire_stage_pkg::*;
#(
  parameter int N           = `N,
  parameter int ARCH_REG_SZ = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  rob_entry_t [N-1:0]    head_entries,
  input  logic [N-1:0]          head_valids,
  input  rob_idx_t              head_idx,
  output logic [N:0]            retire_count,
  output logic                  mispredict,
  output rob_idx_t              mispred_idx,
  output addr_t                 recover_pc,
  output logic [N-1:0]          free_valid,
  output phys_tag_t [N-1:0]     free_pregs,
  output logic [N-1:0]          amt_valid,
  output reg_idx_t [N-1:0]      amt_areg,
  output phys_tag_t [N-1:0]     amt_preg,
  output logic                  halted
`ifdef RETIRE_STATS_EN
  ,output logic [63:0]          instret
`endif
);

  localparam int unused_arch_reg_sz = ARCH_REG_SZ;

  retire_state_e state, state_next;

  logic [N-1:0] avail, halt_vec, mp_vec, stop_vec, entry_valid;
  logic [N-1:0] retire;
  logic [N:0]   sel_count;
  logic         enable;
  logic         halt_hit, mp_hit;
  rob_idx_t     mp_idx;
  addr_t        mp_pc;
  logic [N-1:0] free_vld, amt_vld;
  logic         unused_valid_bits;

  logic [N-1:0]      free_valid_p1, amt_valid_p1;
  phys_tag_t [N-1:0] free_pregs_p1, amt_preg_p1;
  reg_idx_t [N-1:0]  amt_areg_p1;
  rob_idx_t          mispred_idx_p1;
  addr_t             recover_pc_p1;

  always_comb begin
    avail       = '0;
    halt_vec    = '0;
    mp_vec      = '0;
    entry_valid = '0;
    for (int i = 0; i < N; i++) begin
      avail[i]       = head_valids[i] & head_entries[i].complete;
      halt_vec[i]    = head_entries[i].halt;
      mp_vec[i]      = head_entries[i].is_branch & head_entries[i].mispredict;
      entry_valid[i] = head_entries[i].valid;
    end
  end

  // Occupancy comes from head_valids; the per-entry valid bit is redundant.
  assign unused_valid_bits = ^entry_valid;
  assign stop_vec = halt_vec | mp_vec;

  // Reset suppresses retirement in the same cycle so nothing leaks to the ROB.
  assign enable = (state == RUN) && !reset;

  retire_select #(.N(N)) u_select (
    .enable (enable),
    .avail  (avail),
    .stop   (stop_vec),
    .retire (retire),
    .count  (sel_count)
  );

  assign retire_count = sel_count;

  always_comb begin
    halt_hit = 1'b0;
    mp_hit   = 1'b0;
    mp_idx   = '0;
    mp_pc    = '0;
    for (int i = 0; i < N; i++) begin
      if (retire[i] && halt_vec[i]) halt_hit = 1'b1;
      if (retire[i] && mp_vec[i]) begin
        mp_hit = 1'b1;
        mp_pc  = head_entries[i].target_pc;
        mp_idx = rob_idx_t'((int'(head_idx) + i) % ROB_SZ);
      end
    end
  end

  // Younger writes to the same areg shadow older ones within a group.
  always_comb begin
    free_vld = '0;
    amt_vld  = '0;
    for (int i = 0; i < N; i++) begin
      free_vld[i] = retire[i] & head_entries[i].has_dest;
      amt_vld[i]  = retire[i] & head_entries[i].has_dest;
      for (int j = i + 1; j < N; j++) begin
        if (retire[j] && head_entries[j].has_dest &&
            head_entries[j].dest_areg == head_entries[i].dest_areg)
          amt_vld[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mispredict = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        if (halt_hit)    state_next = HALTED;
        else if (mp_hit) state_next = RECOVER;
      end
      RECOVER: begin
        mispredict = 1'b1;
        state_next = RUN;
      end
      HALTED: begin
        halted     = 1'b1;
        state_next = HALTED;
      end
      default: state_next = RUN;
    endcase
  end

  // ---- stage p1: registered retirement side effects ----
  always_ff @(posedge clock) begin
    if (reset) begin
      free_valid_p1  <= '0;
      amt_valid_p1   <= '0;
      mispred_idx_p1 <= '0;
      recover_pc_p1  <= '0;
    end else begin
      free_valid_p1 <= free_vld;
      amt_valid_p1  <= amt_vld;
      if (mp_hit) begin
        mispred_idx_p1 <= mp_idx;
        recover_pc_p1  <= mp_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      free_pregs_p1[i] <= head_entries[i].old_preg;
      amt_areg_p1[i]   <= head_entries[i].dest_areg;
      amt_preg_p1[i]   <= head_entries[i].dest_preg;
    end
  end

  assign free_valid  = free_valid_p1;
  assign free_pregs  = free_pregs_p1;
  assign amt_valid   = amt_valid_p1;
  assign amt_areg    = amt_areg_p1;
  assign amt_preg    = amt_preg_p1;
  assign mispred_idx = mispred_idx_p1;
  assign recover_pc  = recover_pc_p1;

`ifdef RETIRE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) instret <= '0;
    else       instret <= instret + 64'(retire_count);
  end
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage -- directed bench for retire_stage (N=3) with a
// cycle-level reference model and literal spot checks.
module tb_retire_stage;
  import retire_stage_pkg::*;

  localparam int N = 3;

  logic              clock = 1'b0;
  logic              reset;
  rob_entry_t [N-1:0] head_entries;
  logic [N-1:0]      head_valids;
  rob_idx_t          head_idx;
  logic [N:0]        retire_count;
  logic              mispredict;
  rob_idx_t          mispred_idx;
  addr_t             recover_pc;
  logic [N-1:0]      free_valid;
  phys_tag_t [N-1:0] free_pregs;
  logic [N-1:0]      amt_valid;
  reg_idx_t [N-1:0]  amt_areg;
  phys_tag_t [N-1:0] amt_preg;
  logic              halted;
`ifdef RETIRE_STATS_EN
  logic [63:0]       instret;
`endif

  retire_stage #(.N(N), .ARCH_REG_SZ(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .head_entries (head_entries),
    .head_valids  (head_valids),
    .head_idx     (head_idx),
    .retire_count (retire_count),
    .mispredict   (mispredict),
    .mispred_idx  (mispred_idx),
    .recover_pc   (recover_pc),
    .free_valid   (free_valid),
    .free_pregs   (free_pregs),
    .amt_valid    (amt_valid),
    .amt_areg     (amt_areg),
    .amt_preg     (amt_preg),
    .halted       (halted)
`ifdef RETIRE_STATS_EN
    ,.instret     (instret)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_state;   // 0 run, 1 recovering, 2 halted
  rob_idx_t  m_idx;
  addr_t     m_pc;
  logic [N-1:0] m_free_v, m_amt_v;
  phys_tag_t m_free_p [N];
  reg_idx_t  m_amt_a  [N];
  phys_tag_t m_amt_p  [N];
  bit        started = 1'b0;

  function automatic bit is_stop(input rob_entry_t e);
    return e.halt || (e.is_branch && e.mispredict);
  endfunction

  // Length of the retiring prefix for the current inputs.
  function automatic int model_count();
    int k;
    if (reset || m_state != 0) return 0;
    k = 0;
    while (k < N && head_valids[k] && head_entries[k].complete) begin
      k++;
      if (is_stop(head_entries[k-1])) break;
    end
    return k;
  endfunction

  task automatic model_step();
    int k;
    rob_entry_t last;
    k = model_count();
    if (reset) begin
      m_state  = 0;
      m_idx    = '0;
      m_pc     = '0;
      m_free_v = '0;
      m_amt_v  = '0;
      started  = 1'b1;
      return;
    end
    m_free_v = '0;
    m_amt_v  = '0;
    for (int i = 0; i < k; i++) begin
      if (head_entries[i].has_dest) begin
        m_free_v[i] = 1'b1;
        m_free_p[i] = head_entries[i].old_preg;
        m_amt_v[i]  = 1'b1;
        m_amt_a[i]  = head_entries[i].dest_areg;
        m_amt_p[i]  = head_entries[i].dest_preg;
        for (int j = i + 1; j < k; j++)
          if (head_entries[j].has_dest && head_entries[j].dest_areg == head_entries[i].dest_areg)
            m_amt_v[i] = 1'b0;
      end
    end
    case (m_state)
      0: if (k > 0) begin
           last = head_entries[k-1];
           if (last.halt) m_state = 2;
           else if (last.is_branch && last.mispredict) begin
             m_state = 1;
             m_idx   = rob_idx_t'((int'(head_idx) + k - 1) % ROB_SZ);
             m_pc    = last.target_pc;
           end
         end
      1: m_state = 0;
      default: m_state = 2;
    endcase
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (started) begin
      check("retire_count", 64'(retire_count), 64'(model_count()));
      check("mispredict",   64'(mispredict),   64'(m_state == 1));
      check("halted",       64'(halted),       64'(m_state == 2));
      check("mispred_idx",  64'(mispred_idx),  64'(m_idx));
      check("recover_pc",   64'(recover_pc),   64'(m_pc));
      check("free_valid",   64'(free_valid),   64'(m_free_v));
      check("amt_valid",    64'(amt_valid),    64'(m_amt_v));
      for (int i = 0; i < N; i++) begin
        if (m_free_v[i]) check("free_pregs", 64'(free_pregs[i]), 64'(m_free_p[i]));
        if (m_amt_v[i]) begin
          check("amt_areg", 64'(amt_areg[i]), 64'(m_amt_a[i]));
          check("amt_preg", 64'(amt_preg[i]), 64'(m_amt_p[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic rob_entry_t mk(input bit c, input bit hd, input int areg, input int preg,
                                    input int old, input bit mp, input logic [31:0] tgt, input bit hlt);
    rob_entry_t e;
    e           = '0;
    e.valid     = 1'b1;
    e.complete  = c;
    e.has_dest  = hd;
    e.dest_areg = reg_idx_t'(areg);
    e.dest_preg = phys_tag_t'(preg);
    e.old_preg  = phys_tag_t'(old);
    e.is_branch = mp;
    e.mispredict = mp;
    e.target_pc = tgt;
    e.halt      = hlt;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    head_entries = '0;
    head_valids  = '0;
  endtask

  task automatic load_mispred(input bit at_slot0);
    head_idx = rob_idx_t'(ROB_SZ - 1);
    head_valids = 3'b111;
    if (at_slot0) begin
      head_entries[0] = mk(1, 0, 0, 0, 0, 1, 32'h40, 0);
      head_entries[1] = mk(1, 1, 2, 41, 14, 0, 0, 0);
    end else begin
      head_entries[0] = mk(1, 1, 1, 40, 13, 0, 0, 0);
      head_entries[1] = mk(1, 0, 0, 0, 0, 1, 32'h40, 0);
    end
    head_entries[2] = mk(1, 1, 3, 42, 15, 0, 0, 0);
  endtask

  task automatic load_single();
    clear_in();
    head_idx = rob_idx_t'(1);
    head_valids = 3'b001;
    head_entries[0] = mk(1, 1, 9, 50, 25, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    head_idx = '0;
    clear_in();
    tick(); tick();
    @(negedge clock);
    check("rst_retire_count", 64'(retire_count), 64'd0);
    check("rst_mispredict",   64'(mispredict),   64'd0);
    check("rst_halted",       64'(halted),       64'd0);
    check("rst_free_valid",   64'(free_valid),   64'd0);
    check("rst_amt_valid",    64'(amt_valid),    64'd0);
    check("rst_recover_pc",   64'(recover_pc),   64'd0);
    tick();
    reset = 1'b0;

    // Three ordinary retirements
    head_idx = rob_idx_t'(4);
    head_valids = 3'b111;
    head_entries[0] = mk(1, 1, 1, 20, 10, 0, 0, 0);
    head_entries[1] = mk(1, 1, 2, 21, 11, 0, 0, 0);
    head_entries[2] = mk(1, 1, 3, 22, 12, 0, 0, 0);
    @(negedge clock);
    check("all3_count", 64'(retire_count), 64'd3);
    tick(); clear_in();
    @(negedge clock);
    check("all3_free_valid", 64'(free_valid), 64'h7);
    check("all3_free0", 64'(free_pregs[0]), 64'd10);
    check("all3_free1", 64'(free_pregs[1]), 64'd11);
    check("all3_free2", 64'(free_pregs[2]), 64'd12);
    tick();

    // Incomplete middle slot
    head_valids = 3'b111;
    head_entries[0] = mk(1, 1, 1, 20, 10, 0, 0, 0);
    head_entries[1] = mk(0, 1, 2, 21, 11, 0, 0, 0);
    head_entries[2] = mk(1, 1, 3, 22, 12, 0, 0, 0);
    @(negedge clock);
    check("incomplete_count", 64'(retire_count), 64'd1);
    tick(); clear_in();
    @(negedge clock);
    check("incomplete_free_valid", 64'(free_valid), 64'h1);
    tick();

    // Occupancy gap
    head_valids = 3'b101;
    head_entries[0] = mk(1, 1, 1, 20, 10, 0, 0, 0);
    head_entries[2] = mk(1, 1, 3, 22, 12, 0, 0, 0);
    @(negedge clock);
    check("gap_count", 64'(retire_count), 64'd1);
    tick(); clear_in(); tick();

    // Same areg in slots 0 and 2
    head_valids = 3'b111;
    head_entries[0] = mk(1, 1, 5, 30, 16, 0, 0, 0);
    head_entries[1] = mk(1, 1, 7, 31, 17, 0, 0, 0);
    head_entries[2] = mk(1, 1, 5, 32, 18, 0, 0, 0);
    @(negedge clock);
    check("waw_count", 64'(retire_count), 64'd3);
    tick(); clear_in();
    @(negedge clock);
    check("waw_amt_valid", 64'(amt_valid), 64'h6);
    check("waw_amt_areg2", 64'(amt_areg[2]), 64'd5);
    check("waw_amt_preg2", 64'(amt_preg[2]), 64'd32);
    tick();

    // Mispredicted branch in slot 1 with head at the last ROB index
    load_mispred(1'b0);
    @(negedge clock);
    check("mp_count", 64'(retire_count), 64'd2);
    tick();
    @(negedge clock);
    check("mp_pulse",       64'(mispredict),   64'd1);
    check("mp_idx_wrap",    64'(mispred_idx),  64'd0);
    check("mp_recover_pc",  64'(recover_pc),   64'h40);
    check("mp_recover_cnt", 64'(retire_count), 64'd0);
    tick();
    load_single();
    @(negedge clock);
    check("mp_after_pulse", 64'(mispredict),   64'd0);
    check("mp_after_count", 64'(retire_count), 64'd1);
    tick(); clear_in(); tick();

    // Reset in the same cycle a mispredicted branch would retire
    reset = 1'b1;
    load_mispred(1'b1);
    @(negedge clock);
    check("rstmp_count", 64'(retire_count), 64'd0);
    tick();
    reset = 1'b0;
    clear_in();
    @(negedge clock);
    check("rstmp_mispredict", 64'(mispredict), 64'd0);
    check("rstmp_recover_pc", 64'(recover_pc), 64'd0);
    tick();
    load_single();
    @(negedge clock);
    check("rstmp_run_count", 64'(retire_count), 64'd1);
    tick(); clear_in(); tick();

    // Halt at the head
    head_idx = rob_idx_t'(8);
    head_valids = 3'b111;
    head_entries[0] = mk(1, 0, 0, 0, 0, 0, 0, 1);
    head_entries[1] = mk(1, 1, 4, 33, 19, 0, 0, 0);
    head_entries[2] = mk(1, 1, 6, 34, 20, 0, 0, 0);
    @(negedge clock);
    check("halt_count", 64'(retire_count), 64'd1);
    tick();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("halt_halted", 64'(halted),       64'd1);
      check("halt_hold",   64'(retire_count), 64'd0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_single();
    @(negedge clock);
    check("halt_reset_halted", 64'(halted),       64'd0);
    check("halt_reset_count",  64'(retire_count), 64'd1);
    tick(); clear_in(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
